// File: rtl/seg_skid_reg_ysyx_23060136_if.sv
// Handshake bundle for a pipeline segment register: upstream entry with forwarding
// overrides on one side, head entry and occupancy on the other.
interface seg_skid_reg_ysyx_23060136_if #(
  parameter int PAYLOAD_W = 128,
  parameter int N_OPS     = 3,
  parameter int OP_W      = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PAYLOAD_W-1:0]    in_payload;
  logic [N_OPS*OP_W-1:0]   in_ops;
  logic [N_OPS-1:0]        fwd_hazard;
  logic [N_OPS*OP_W-1:0]   fwd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [PAYLOAD_W-1:0]    out_payload;
  logic [N_OPS*OP_W-1:0]   out_ops;
  logic [1:0]              occ;

  // Upstream/downstream driver side.
  modport master (
    output in_valid, in_payload, in_ops, fwd_hazard, fwd_data, out_ready,
    input  in_ready, out_valid, out_payload, out_ops, occ
  );

  // The segment register itself.
  modport slave (
    input  in_valid, in_payload, in_ops, fwd_hazard, fwd_data, out_ready,
    output in_ready, out_valid, out_payload, out_ops, occ
  );
endinterface

// File: rtl/seg_skid_reg_ysyx_23060136.sv
// Pipeline segment register with capture-time operand forwarding, synchronous flush
// and an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module seg_skid_reg_ysyx_23060136 #(
  parameter int                   PAYLOAD_W   = 128,
  parameter int                   N_OPS       = 3,
  parameter int                   OP_W        = 32,
  parameter logic [PAYLOAD_W-1:0] RST_PAYLOAD = '0,
  parameter bit                   SKID        = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  seg_skid_reg_ysyx_23060136_if.slave   bus
);
  localparam int OPS_W = N_OPS * OP_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_pl_q, main_pl_d;
  logic [OPS_W-1:0]     main_ops_q, main_ops_d;
  logic [PAYLOAD_W-1:0] skid_pl_q, skid_pl_d;
  logic [OPS_W-1:0]     skid_ops_q, skid_ops_d;
  logic [OPS_W-1:0]     cap_ops;
  logic                 in_ready;
  logic                 out_valid;
  logic                 in_hs;
  logic                 out_hs;

  // Forwarding is merged only into the register that captures the entry.
  always_comb begin
    cap_ops = bus.in_ops;
    for (int i = 0; i < N_OPS; i++) begin
      if (bus.fwd_hazard[i]) cap_ops[i*OP_W +: OP_W] = bus.fwd_data[i*OP_W +: OP_W];
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_hs     = bus.in_valid & in_ready;
  assign out_hs    = out_valid & bus.out_ready;

  if (SKID) begin : g_skid
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (rst) in_ready_q <= 1'b1;
      else     in_ready_q <= (state_d != FULL);
    end
    assign in_ready = in_ready_q;
  end else begin : g_single
    assign in_ready = ~out_valid | bus.out_ready;
  end

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    state_d    = state_q;
    main_pl_d  = main_pl_q;
    main_ops_d = main_ops_q;
    skid_pl_d  = skid_pl_q;
    skid_ops_d = skid_ops_q;
    unique case (state_q)
      EMPTY: if (in_hs) begin
        state_d    = BUSY;
        main_pl_d  = bus.in_payload;
        main_ops_d = cap_ops;
      end
      BUSY: if (in_hs && out_hs) begin
        main_pl_d  = bus.in_payload;
        main_ops_d = cap_ops;
      end else if (in_hs && SKID) begin
        state_d    = FULL;
        skid_pl_d  = bus.in_payload;
        skid_ops_d = cap_ops;
      end else if (out_hs) begin
        state_d    = EMPTY;
        main_pl_d  = RST_PAYLOAD;
        main_ops_d = '0;
      end
      FULL: if (out_hs) begin
        state_d    = BUSY;
        main_pl_d  = skid_pl_q;
        main_ops_d = skid_ops_q;
        skid_pl_d  = RST_PAYLOAD;
        skid_ops_d = '0;
      end
      default: state_d = EMPTY;
    endcase
    // Flush kills everything held; a coincident out_hs already sampled the outputs.
    if (flush) begin
      state_d    = EMPTY;
      main_pl_d  = RST_PAYLOAD;
      main_ops_d = '0;
      skid_pl_d  = RST_PAYLOAD;
      skid_ops_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so an empty stage presents a NOP bubble downstream.
    if (rst) begin
      state_q    <= EMPTY;
      main_pl_q  <= RST_PAYLOAD;
      main_ops_q <= '0;
      skid_pl_q  <= RST_PAYLOAD;
      skid_ops_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q    <= state_d;
      main_pl_q  <= main_pl_d;
      main_ops_q <= main_ops_d;
      skid_pl_q  <= skid_pl_d;
      skid_ops_q <= skid_ops_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_payload = main_pl_q;
  assign bus.out_ops     = main_ops_q;
  assign bus.occ         = 2'(state_q);
endmodule

// File: tb/tb_seg_skid_reg_ysyx_23060136.sv
// Bench for both builds (SKID=1 and SKID=0) against a capacity-bounded FIFO model:
// a vector table, a forwarding sequence and a randomized run.
module tb_seg_skid_reg_ysyx_23060136;
  localparam int PW    = 128;
  localparam int NO    = 3;
  localparam int OW    = 32;
  localparam int OPS_W = NO * OW;
  localparam logic [PW-1:0] RST_P = {64'h0, 32'h8000_0000, 32'h0000_0013};

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  seg_skid_reg_ysyx_23060136_if #(.PAYLOAD_W(PW), .N_OPS(NO), .OP_W(OW)) bus1 ();
  seg_skid_reg_ysyx_23060136_if #(.PAYLOAD_W(PW), .N_OPS(NO), .OP_W(OW)) bus0 ();

  seg_skid_reg_ysyx_23060136 #(
    .PAYLOAD_W(PW), .N_OPS(NO), .OP_W(OW), .RST_PAYLOAD(RST_P), .SKID(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(bus1));

  seg_skid_reg_ysyx_23060136 #(
    .PAYLOAD_W(PW), .N_OPS(NO), .OP_W(OW), .RST_PAYLOAD(RST_P), .SKID(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(bus0));

  typedef struct {
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [31:0]       pc;
    logic [OPS_W-1:0]  ops;
    logic [NO-1:0]     haz;
    logic [OPS_W-1:0]  fwd;
  } stim_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic        exp_valid;
    logic [1:0]  exp_occ;
    logic        exp_ir;
    logic [31:0] exp_pc;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per build (index 1 = skid, 0 = single) a FIFO of entries.
  logic [PW-1:0]    m_pl  [2][2];
  logic [OPS_W-1:0] m_ops [2][2];
  int               m_cnt [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk_pl(input logic [31:0] pc);
    return {64'h0123_4567_89AB_CDEF, pc, 32'h0000_0033};
  endfunction

  function automatic logic [OPS_W-1:0] merged(input stim_t s);
    logic [OPS_W-1:0] r;
    for (int i = 0; i < NO; i++)
      r[i*OW +: OW] = s.haz[i] ? s.fwd[i*OW +: OW] : s.ops[i*OW +: OW];
    return r;
  endfunction

  // Drive one cycle, check in_ready before the edge, advance the model, check outputs after.
  task automatic apply(input stim_t s);
    logic mir, ihs, ohs, dut_ir, dut_ov;
    logic [1:0] dut_occ;
    logic [PW-1:0] dut_pl;
    logic [OPS_W-1:0] dut_ops;
    rst   = s.rst;
    flush = s.flush;
    bus1.in_valid = s.in_valid;  bus0.in_valid = s.in_valid;
    bus1.out_ready = s.out_ready; bus0.out_ready = s.out_ready;
    bus1.in_payload = mk_pl(s.pc); bus0.in_payload = mk_pl(s.pc);
    bus1.in_ops = s.ops;         bus0.in_ops = s.ops;
    bus1.fwd_hazard = s.haz;     bus0.fwd_hazard = s.haz;
    bus1.fwd_data = s.fwd;       bus0.fwd_data = s.fwd;
    #1;
    for (int b = 0; b < 2; b++) begin
      mir = (b == 1) ? (m_cnt[b] < 2) : (m_cnt[b] == 0 || s.out_ready);
      dut_ir = (b == 1) ? bus1.in_ready : bus0.in_ready;
      check($sformatf("skid%0d.in_ready", b), {127'b0, dut_ir}, {127'b0, mir});
      ihs = s.in_valid & mir;
      ohs = (m_cnt[b] > 0) & s.out_ready;
      if (s.rst || s.flush) begin
        m_cnt[b] = 0;
      end else begin
        if (ohs) begin
          m_pl[b][0] = m_pl[b][1]; m_ops[b][0] = m_ops[b][1];
          m_cnt[b]--;
        end
        if (ihs) begin
          m_pl[b][m_cnt[b]]  = mk_pl(s.pc);
          m_ops[b][m_cnt[b]] = merged(s);
          m_cnt[b]++;
        end
      end
    end
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      dut_ov  = (b == 1) ? bus1.out_valid   : bus0.out_valid;
      dut_occ = (b == 1) ? bus1.occ         : bus0.occ;
      dut_pl  = (b == 1) ? bus1.out_payload : bus0.out_payload;
      dut_ops = (b == 1) ? bus1.out_ops     : bus0.out_ops;
      check($sformatf("skid%0d.out_valid", b), {127'b0, dut_ov}, {127'b0, m_cnt[b] > 0});
      check($sformatf("skid%0d.occ", b), {126'b0, dut_occ}, 128'(m_cnt[b]));
      check($sformatf("skid%0d.out_payload", b), dut_pl, (m_cnt[b] > 0) ? m_pl[b][0] : RST_P);
      check($sformatf("skid%0d.out_ops", b), {32'b0, dut_ops},
            {32'b0, (m_cnt[b] > 0) ? m_ops[b][0] : {OPS_W{1'b0}}});
    end
  endtask

  stim_t s;
  vec_t  tbl [20];

  initial begin
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 2'd1, 1'b1, 32'h80000000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h80000004, 1'b1, 2'd1, 1'b1, 32'h80000004};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h80000008, 1'b1, 2'd1, 1'b1, 32'h80000008};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8000000C, 1'b1, 2'd2, 1'b0, 32'h80000008};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80000010, 1'b1, 2'd2, 1'b0, 32'h80000008};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80000010, 1'b1, 2'd2, 1'b0, 32'h80000008};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h80000010, 1'b1, 2'd1, 1'b1, 32'h8000000C};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h80000010, 1'b1, 2'd1, 1'b1, 32'h80000010};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80000014, 1'b1, 2'd2, 1'b0, 32'h80000010};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h80000018, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h80000018, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8000001C, 1'b1, 2'd1, 1'b1, 32'h8000001C};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80000020, 1'b1, 2'd2, 1'b0, 32'h8000001C};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h80000024, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h80000028, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8000002C, 1'b0, 2'd0, 1'b1, 32'h80000000};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8000002C, 1'b0, 2'd0, 1'b1, 32'h80000000};

    // Power-on: bring both builds out of the unknown state before any comparison.
    rst = 1'b1; flush = 1'b0;
    bus1.in_valid = 1'b0; bus0.in_valid = 1'b0;
    bus1.out_ready = 1'b1; bus0.out_ready = 1'b1;
    bus1.in_payload = '0; bus0.in_payload = '0;
    bus1.in_ops = '0; bus0.in_ops = '0;
    bus1.fwd_hazard = '0; bus0.fwd_hazard = '0;
    bus1.fwd_data = '0; bus0.fwd_data = '0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      s.rst = tbl[i].rst; s.flush = tbl[i].flush;
      s.in_valid = tbl[i].in_valid; s.out_ready = tbl[i].out_ready;
      s.pc = tbl[i].pc;
      s.ops = {tbl[i].pc ^ 32'h3, tbl[i].pc ^ 32'h2, tbl[i].pc ^ 32'h1};
      s.haz = '0; s.fwd = '0;
      apply(s);
      check($sformatf("vec%0d.out_valid", i), {127'b0, bus1.out_valid}, {127'b0, tbl[i].exp_valid});
      check($sformatf("vec%0d.occ", i), {126'b0, bus1.occ}, {126'b0, tbl[i].exp_occ});
      check($sformatf("vec%0d.in_ready", i), {127'b0, bus1.in_ready}, {127'b0, tbl[i].exp_ir});
      check($sformatf("vec%0d.pc", i), {96'b0, bus1.out_payload[63:32]}, {96'b0, tbl[i].exp_pc});
    end

    // Forwarding: overrides apply at capture only, even while an entry waits in skid.
    s = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, {32'h22222222, 32'h11111111, 32'h00000000},
          3'b010, {32'hCCCCCCCC, 32'hDEADBEEF, 32'hBBBBBBBB}};
    apply(s);
    check("fwd.capture_main", {32'b0, bus1.out_ops}, {32'b0, 32'h22222222, 32'hDEADBEEF, 32'h00000000});
    s.pc = 32'h104; s.fwd = {32'hCCCCCCCC, 32'hCAFEF00D, 32'hBBBBBBBB};
    apply(s);
    check("fwd.occ_full", {126'b0, bus1.occ}, 128'd2);
    s.in_valid = 1'b0; s.haz = 3'b111; s.fwd = {3{32'h12345678}};
    apply(s);
    s.out_ready = 1'b1;
    apply(s);
    check("fwd.skid_kept", {32'b0, bus1.out_ops}, {32'b0, 32'h22222222, 32'hCAFEF00D, 32'h00000000});
    check("fwd.skid_pc", {96'b0, bus1.out_payload[63:32]}, 128'h104);
    apply(s);
    check("fwd.bubble_ops", {32'b0, bus1.out_ops}, 128'd0);
    check("fwd.bubble_payload", bus1.out_payload, RST_P);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      s.rst       = ($urandom_range(0, 63) == 0);
      s.flush     = ($urandom_range(0, 15) == 0);
      s.in_valid  = ($urandom_range(0, 3) != 0);
      s.out_ready = ($urandom_range(0, 2) != 0);
      s.pc        = $urandom;
      s.ops       = {$urandom, $urandom, $urandom};
      s.haz       = 3'($urandom);
      s.fwd       = {$urandom, $urandom, $urandom};
      apply(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_skid_reg_ysyx_23060136.md
# seg_skid_reg_ysyx_23060136

Parametrised pipeline segment register for the ysyx_23060136 core, the generalised replacement for the fixed per-stage segment registers (IFU→IDU, IDU→EXU, EXU→MEM, MEM→WBU). It carries a generic payload bundle plus N forwardable operand words across a valid/ready handshake. It applies forwarding-unit overrides at capture time and supports synchronous flush. An optional 2-entry skid buffer breaks the ready path, so stalls no longer propagate combinationally upstream.

## Interface
Parameters:
- PAYLOAD_W, 128: width of the non-forwardable bundle (pc, inst, control bits).
- N_OPS, 3: number of forwardable operand channels (rs1, rs2, csr_rs).
- OP_W, 32: width of each operand.
- RST_PAYLOAD, {PAYLOAD_W{1'b0}}: payload value loaded on reset, flush or drain. Stages set the pc field to PC_RST and the inst field to NOP.
- SKID, 1: 1 selects the 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- flush, in, 1: branch/trap flush; kills all held entries.
- in_valid, in, 1: upstream entry valid.
- in_ready, out, 1: block can accept an entry.
- in_payload, in, PAYLOAD_W: upstream bundle.
- in_ops, in, N_OPS*OP_W: operand words from the register file; channel i is at [i*OP_W +: OP_W].
- fwd_hazard, in, N_OPS: per-channel forward select.
- fwd_data, in, N_OPS*OP_W: forwarded operand values.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: downstream accepts the head entry.
- out_payload, out, PAYLOAD_W: head payload.
- out_ops, out, N_OPS*OP_W: head operands.
- occ, out, 2: number of entries held (0..2; max 1 when SKID=0).

## Operation
- An input handshake (in_hs) is in_valid & in_ready. An output handshake (out_hs) is out_valid & out_ready.
- Captured operand for channel i = fwd_hazard[i] ? fwd_data[i] : in_ops[i]. This merge is applied only at the capture edge, into whichever register receives the entry. Held entries are never re-forwarded; the hazard unit guarantees this is safe.
- Storage is a main register (drives the out_* ports) and a skid register (SKID=1 only).
- States (encoded by occ):
  - EMPTY (0), BUSY (1), FULL (2).
  - EMPTY: in_hs → BUSY, main ← input.
  - BUSY:
    - in_hs & out_hs → BUSY, main ← input.
    - in_hs & ~out_hs → FULL, skid ← input.
    - ~in_hs & out_hs → EMPTY.
    - Otherwise hold.
  - FULL: in_ready=0. out_hs → BUSY, main ← skid, skid cleared. Otherwise hold.
- Whenever main becomes empty (drain, flush or rst), main payload ← RST_PAYLOAD and ops ← 0, so downstream combinational logic sees a NOP bubble. The skid register is cleared the same way.
- flush takes priority over everything in the same cycle:
  - Next state is EMPTY.
  - Any coincident in_hs is discarded.
  - A coincident out_hs still completes, since downstream samples the current outputs.
- rst has the same effect as flush and overrides it.
- in_ready:
  - SKID=1: in_ready = (occ != 2). It is registered and independent of out_ready and flush.
  - SKID=0: in_ready = ~out_valid | out_ready (combinational). FULL is unreachable.
- out_valid = (occ != 0).

## Timing
- Reset values: out_valid=0, occ=0, out_payload=RST_PAYLOAD, out_ops=0. in_ready=1 one cycle after rst deasserts (SKID=1: in_ready=1 even during rst; entries offered are dropped).
- Latency: 1 cycle from in_hs to the entry appearing on out_*.
- Throughput: 1 entry/cycle when out_ready stays high.
- Stall cost (SKID=1): when out_ready drops, at most one extra entry is absorbed into skid. in_ready falls on the following edge.
- Order: strictly FIFO. The skid entry is never overtaken.
- flush asserted for several cycles: the block stays EMPTY with out_valid=0 throughout.
- rst mid-operation (FULL): both entries are dropped and outputs return to reset values on that edge.

## Test plan
- Reset/bubble: assert rst for 2 cycles with in_valid=1 and payload 0xAA.. → out_valid=0, out_payload=RST_PAYLOAD, occ=0, and no entry emerges afterwards.
- Streaming: stream pc 0x80000000, 0x80000004, 0x80000008 with out_ready=1 → each appears exactly 1 cycle after its in_hs, occ stays 1, no gaps.
- Skid absorb: drop out_ready for 3 cycles while in_valid stays 1 → occ goes 1→2, in_ready=0 after one edge; on release, entries emerge in order with no loss or duplication.
- Forwarding: channel 1 with in_ops=0x11111111, fwd_hazard=3'b010, fwd_data=0xDEADBEEF → out_ops ch1=0xDEADBEEF and ch0/ch2 unchanged. A value later changed on fwd_data while the entry is held in skid must not alter it.
- Flush: flush in FULL with a coincident in_hs → next cycle occ=0, out_valid=0, payload=RST_PAYLOAD, and the flushed-cycle input never appears.
- SKID=0 build: the same streaming and stall sequences → occ ≤ 1, and in_ready equals ~out_valid | out_ready every cycle.
